reorder_buffer: RTL and testbench

//  In-order retirement queue between dispatch and the register alias table.

---
 rtl/reorder_buffer.sv | 103 ++++++++++
 tb/tb_reorder_buffer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue that hands out rename tags, captures writebacks
// and retires entries in program order while sharing one alias-table port between alloc and commit.
module reorder_buffer #(
    parameter int ROB_ENTRY       = 4,
    parameter int ARCH_ENTRY      = 32,
    parameter int XLEN            = 32,
    parameter int ROB_ENTRY_LOG2  = $clog2(ROB_ENTRY),
    parameter int ARCH_ENTRY_LOG2 = $clog2(ARCH_ENTRY)
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    input  logic                       flush,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic                       alloc_has_rd,
    input  logic [ARCH_ENTRY_LOG2-1:0] alloc_arch_id,
    output logic [ROB_ENTRY_LOG2-1:0]  alloc_tag,
    input  logic                       wb_valid,
    input  logic [ROB_ENTRY_LOG2-1:0]  wb_tag,
    input  logic [XLEN-1:0]            wb_data,
    input  logic [ROB_ENTRY_LOG2-1:0]  query_tag,
    output logic                       query_ready,
    output logic [XLEN-1:0]            query_data,
    output logic                       commit_valid,
    output logic                       commit_has_rd,
    output logic [ARCH_ENTRY_LOG2-1:0] commit_arch_id,
    output logic [XLEN-1:0]            commit_data,
    output logic                       rat_register_request,
    output logic                       rat_register_remove,
    output logic [ARCH_ENTRY_LOG2-1:0] rat_register_arch_id,
    output logic [ROB_ENTRY_LOG2-1:0]  rat_register_alias
);
    localparam int CW = ROB_ENTRY_LOG2 + 1;

    logic [ROB_ENTRY-1:0]       valid, done, has_rd;
    logic [ARCH_ENTRY_LOG2-1:0] arch_id [ROB_ENTRY];
    logic [XLEN-1:0]            data [ROB_ENTRY];
    logic [ROB_ENTRY_LOG2-1:0]  head, tail;
    logic [CW-1:0]              count;
    logic                       alloc_fire, alloc_rd, younger_match;

    assign alloc_ready   = count != CW'(ROB_ENTRY);
    assign alloc_fire    = alloc_valid & alloc_ready & ~flush;
    assign alloc_rd      = alloc_has_rd & (alloc_arch_id != '0);
    assign alloc_tag     = tail;
    assign query_ready   = valid[query_tag] & done[query_tag];
    assign query_data    = data[query_tag];
    // An alloc needing the alias-table port wins; a head that also needs it waits a cycle.
    assign commit_valid  = valid[head] & done[head] & ~flush & ~(alloc_fire & alloc_rd & has_rd[head]);
    assign commit_has_rd = has_rd[head];
    assign commit_arch_id = arch_id[head];
    assign commit_data   = data[head];
    assign rat_register_request = alloc_fire & alloc_rd;
    assign rat_register_remove  = commit_valid & has_rd[head] & ~younger_match;
    assign rat_register_arch_id = rat_register_request ? alloc_arch_id :
                                  rat_register_remove  ? arch_id[head] : '0;
    assign rat_register_alias   = tail;

    always_comb begin
        younger_match = 1'b0;
        for (int i = 0; i < ROB_ENTRY; i++)
            if (ROB_ENTRY_LOG2'(i) != head && valid[i] && has_rd[i] && arch_id[i] == arch_id[head])
                younger_match = 1'b1;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            valid  <= '0;
            done   <= '0;
            has_rd <= '0;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            for (int i = 0; i < ROB_ENTRY; i++) begin
                arch_id[i] <= '0;
                data[i]    <= '0;
            end
        end else if (flush) begin
            valid <= '0;
            done  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire) begin
                valid[tail]   <= 1'b1;
                done[tail]    <= 1'b0;
                has_rd[tail]  <= alloc_rd;
                arch_id[tail] <= alloc_arch_id;
                tail          <= tail + ROB_ENTRY_LOG2'(1);
            end
            if (wb_valid && valid[wb_tag]) begin
                done[wb_tag] <= 1'b1;
                data[wb_tag] <= wb_data;
            end
            if (commit_valid) begin
                valid[head] <= 1'b0;
                head        <= head + ROB_ENTRY_LOG2'(1);
            end
            count <= count + CW'(alloc_fire) - CW'(commit_valid);
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: queue-based reference model checked every cycle, plus directed literal checks.
module tb_reorder_buffer;
    logic        CLK = 1'b0, RSTN = 1'b0;
    logic        flush = 1'b0, alloc_valid = 1'b0, alloc_has_rd = 1'b0;
    logic [4:0]  alloc_arch_id = '0;
    logic        wb_valid = 1'b0;
    logic [1:0]  wb_tag = '0, query_tag = '0;
    logic [31:0] wb_data = '0;
    logic        alloc_ready, query_ready, commit_valid, commit_has_rd;
    logic        rat_register_request, rat_register_remove;
    logic [1:0]  alloc_tag, rat_register_alias;
    logic [4:0]  commit_arch_id, rat_register_arch_id;
    logic [31:0] query_data, commit_data;

    reorder_buffer dut (
        .CLK(CLK), .RSTN(RSTN), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_has_rd(alloc_has_rd),
        .alloc_arch_id(alloc_arch_id), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .query_tag(query_tag), .query_ready(query_ready), .query_data(query_data),
        .commit_valid(commit_valid), .commit_has_rd(commit_has_rd),
        .commit_arch_id(commit_arch_id), .commit_data(commit_data),
        .rat_register_request(rat_register_request), .rat_register_remove(rat_register_remove),
        .rat_register_arch_id(rat_register_arch_id), .rat_register_alias(rat_register_alias)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0, n_bad = 0, cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    typedef struct {
        int          tag;
        bit          rd;
        int          arch;
        bit          done;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   mtail = 0;
    bit   s_fire = 0, s_eff = 0, s_cv = 0;

    always @(negedge CLK) begin
        if (!RSTN) begin
            s_fire = 0;
            s_cv   = 0;
        end else begin
            int  n;
            bit  fire, eff, req, cv, young, rm, qr;
            logic [31:0] qd;
            n = q.size();
            chk("m_ready", alloc_ready, n < 4);
            chk("m_tag", alloc_tag, mtail);
            fire = alloc_valid && n < 4 && !flush;
            eff  = alloc_has_rd && alloc_arch_id != 0;
            req  = fire && eff;
            chk("m_req", rat_register_request, req);
            if (req) begin
                chk("m_req_arch", rat_register_arch_id, alloc_arch_id);
                chk("m_alias", rat_register_alias, mtail);
            end
            cv = n > 0 && q[0].done && !flush && !(req && q[0].rd);
            chk("m_cv", commit_valid, cv);
            young = 0;
            for (int j = 1; j < n; j++)
                if (q[j].rd && q[j].arch == q[0].arch) young = 1;
            rm = cv && q[0].rd && !young;
            chk("m_remove", rat_register_remove, rm);
            if (cv) begin
                chk("m_c_rd", commit_has_rd, q[0].rd);
                chk("m_c_arch", commit_arch_id, q[0].arch);
                chk("m_c_data", commit_data, q[0].data);
            end
            if (rm) chk("m_rm_arch", rat_register_arch_id, q[0].arch);
            qr = 0;
            qd = '0;
            foreach (q[j]) if (q[j].tag == int'(query_tag) && q[j].done) begin
                qr = 1;
                qd = q[j].data;
            end
            chk("m_qready", query_ready, qr);
            if (qr) chk("m_qdata", query_data, qd);
            s_fire = fire;
            s_eff  = eff;
            s_cv   = cv;
        end
    end

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            q.delete();
            mtail = 0;
        end else if (flush) begin
            q.delete();
            mtail = 0;
        end else begin
            ent_t e;
            if (wb_valid)
                foreach (q[j]) if (q[j].tag == int'(wb_tag)) begin
                    e = q[j];
                    e.done = 1;
                    e.data = wb_data;
                    q[j] = e;
                end
            if (s_cv) void'(q.pop_front());
            if (s_fire) begin
                e.tag  = mtail;
                e.rd   = s_eff;
                e.arch = int'(alloc_arch_id);
                e.done = 0;
                e.data = '0;
                q.push_back(e);
                mtail = (mtail + 1) % 4;
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        flush = 0; alloc_valid = 0; alloc_has_rd = 0; alloc_arch_id = '0;
        wb_valid = 0; wb_tag = '0; wb_data = '0;
        query_tag = 2'(cyc);
    endtask

    task automatic alloc(input logic rd, input logic [4:0] arch);
        alloc_valid = 1; alloc_has_rd = rd; alloc_arch_id = arch;
    endtask

    task automatic wb(input logic [1:0] t, input logic [31:0] d);
        wb_valid = 1; wb_tag = t; wb_data = d;
    endtask

    initial begin
        #2;
        chk("rst_ready", alloc_ready, 1);
        chk("rst_tag", alloc_tag, 0);
        chk("rst_cv", commit_valid, 0);
        chk("rst_req", rat_register_request, 0);
        chk("rst_rm", rat_register_remove, 0);
        chk("rst_qready", query_ready, 0);
        #10 RSTN = 1;
        // allocate four entries writing arch 5
        for (int k = 0; k < 4; k++) begin
            step(); alloc(1, 5); #1;
            chk("t1_tag", alloc_tag, k);
            chk("t1_req", rat_register_request, 1);
            chk("t1_alias", rat_register_alias, k);
        end
        step(); alloc(1, 5); #1;
        chk("t1_full", alloc_ready, 0);
        chk("t1_noreq", rat_register_request, 0);
        // out-of-order writeback, in-order retirement
        step(); wb(1, 32'hA); #1;
        chk("t2_cv0", commit_valid, 0);
        step(); wb(0, 32'hB); query_tag = 1; #1;
        chk("t2_qr", query_ready, 1);
        chk("t2_qd", query_data, 32'hA);
        chk("t2_cv1", commit_valid, 0);
        step(); #1;
        chk("t2_c0", commit_valid, 1);
        chk("t2_d0", commit_data, 32'hB);
        chk("t2_rm0", rat_register_remove, 0);
        step(); #1;
        chk("t2_c1", commit_valid, 1);
        chk("t2_d1", commit_data, 32'hA);
        chk("t2_rm1", rat_register_remove, 0);
        step(); wb(2, 32'hC); #1;
        chk("t2_c2n", commit_valid, 0);
        step(); wb(3, 32'hD); #1;
        chk("t2_d2", commit_data, 32'hC);
        chk("t2_rm2", rat_register_remove, 0);
        step(); #1;
        chk("t2_d3", commit_data, 32'hD);
        chk("t2_rm3", rat_register_remove, 1);
        chk("t2_rmarch", rat_register_arch_id, 5);
        step(); #1;
        chk("t2_empty", commit_valid, 0);
        // port conflict between alloc and commit
        step(); alloc(1, 7); #1;
        chk("t3_tag", alloc_tag, 0);
        step(); wb(0, 32'h77);
        step(); alloc(1, 9); #1;
        chk("t3_block", commit_valid, 0);
        chk("t3_req", rat_register_request, 1);
        chk("t3_arch", rat_register_arch_id, 9);
        step(); #1;
        chk("t3_cv", commit_valid, 1);
        chk("t3_rm", rat_register_remove, 1);
        chk("t3_rmarch", rat_register_arch_id, 7);
        step(); wb(1, 32'h99);
        step(); #1;
        chk("t3_rm9", rat_register_arch_id, 9);
        // arch 0 destination never touches the alias table
        step(); alloc(1, 0); #1;
        chk("t4_req", rat_register_request, 0);
        chk("t4_tag", alloc_tag, 2);
        step(); wb(2, 32'h5);
        step(); #1;
        chk("t4_cv", commit_valid, 1);
        chk("t4_rd", commit_has_rd, 0);
        chk("t4_rm", rat_register_remove, 0);
        // flush with three valid entries and a writeback in flight
        for (int k = 0; k < 3; k++) begin
            step(); alloc(1, 5'(3 + k));
        end
        step(); wb(3, 32'h33);
        step(); flush = 1; wb(0, 32'h44); alloc(1, 8); #1;
        chk("t6_cv", commit_valid, 0);
        chk("t6_req", rat_register_request, 0);
        step(); query_tag = 0; #1;
        chk("t6_tag", alloc_tag, 0);
        chk("t6_qr", query_ready, 0);
        chk("t6_cv2", commit_valid, 0);
        chk("t6_ready", alloc_ready, 1);
        // wrap with interleaved alloc and commit
        for (int k = 0; k < 6; k++) begin
            step(); alloc(0, 5'(k + 1));
            if (k > 0) wb(2'(k - 1), 32'(k));
            #1;
            chk("t5_tag", alloc_tag, k % 4);
            chk("t5_ready", alloc_ready, 1);
        end
        step(); wb(1, 32'h6);
        step();
        step(); #1;
        chk("t5_drain", commit_valid, 0);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
